ripple_carry: RTL and testbench

- Parameterisable ripple-carry binary adder: a chain of WIDTH one-bit full adders, with carry propagating from bit 0 to bit WIDTH-1.
- Provides combinational Sum/Cout outputs (zero latency) for datapath use.
- Also provides a registered, valid-qualified copy of the result for pipelined consumers.
- Leaf arithmetic block, used wherever a small unsigned/two's-complement add with carry-in is needed.

---
 rtl/ripple_carry.sv | 92 +++++++++
 tb/tb_ripple_carry.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ripple_carry.sv
// Ripple-carry adder: per-bit full-adder chain with a combinational result and a registered, valid-qualified copy.
// Optional signed-overflow outputs (Ovf/Ovf_r) are enabled by defining RIPPLE_CARRY_OVF_EN.
module ripple_carry #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_r,
    output logic             Cout_r,
    output logic             out_valid
`ifdef RIPPLE_CARRY_OVF_EN
    ,
    output logic             Ovf,
    output logic             Ovf_r
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             cout_d,  cout_q;
    logic             valid_d, valid_q;

    // Carry enters at bit 0 and ripples upward one full adder at a time.
    assign c[0] = Cin;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
        assign s[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Sum  = s;
    assign Cout = c[WIDTH];

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = s;
            cout_d = c[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign Sum_r     = sum_q;
    assign Cout_r    = cout_q;
    assign out_valid = valid_q;

`ifdef RIPPLE_CARRY_OVF_EN
    logic ovf_d, ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign Ovf = c[WIDTH] ^ c[WIDTH-1];

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf_r = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry.sv
// Self-checking bench for ripple_carry at WIDTH=4, 1 and 16 against an arithmetic reference model.
// Overflow checks are included when RIPPLE_CARRY_OVF_EN is defined.
module tb_ripple_carry;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;

    logic [3:0]  a4,  b4;  logic cin4;
    logic [0:0]  a1,  b1;  logic cin1;
    logic [15:0] a16, b16; logic cin16;

    logic [3:0]  s4,  sr4;  logic co4,  cor4,  v4;
    logic [0:0]  s1,  sr1;  logic co1,  cor1,  v1;
    logic [15:0] s16, sr16; logic co16, cor16, v16;
`ifdef RIPPLE_CARRY_OVF_EN
    logic ov4, ovr4, ov1, ovr1, ov16, ovr16;
`endif

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ripple_carry #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(cin4), .in_valid(in_valid),
        .Sum(s4), .Cout(co4), .Sum_r(sr4), .Cout_r(cor4), .out_valid(v4)
`ifdef RIPPLE_CARRY_OVF_EN
        , .Ovf(ov4), .Ovf_r(ovr4)
`endif
    );

    ripple_carry #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_valid(in_valid),
        .Sum(s1), .Cout(co1), .Sum_r(sr1), .Cout_r(cor1), .out_valid(v1)
`ifdef RIPPLE_CARRY_OVF_EN
        , .Ovf(ov1), .Ovf_r(ovr1)
`endif
    );

    ripple_carry #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(cin16), .in_valid(in_valid),
        .Sum(s16), .Cout(co16), .Sum_r(sr16), .Cout_r(cor16), .out_valid(v16)
`ifdef RIPPLE_CARRY_OVF_EN
        , .Ovf(ov16), .Ovf_r(ovr16)
`endif
    );

    // Reference: plain widened addition; signed overflow from operand/result signs.
    logic [4:0]  ref4;
    logic [1:0]  ref1;
    logic [16:0] ref16;
    logic        rov4, rov1, rov16;

    assign ref4  = 5'(a4)  + 5'(b4)  + 5'(cin4);
    assign ref1  = 2'(a1)  + 2'(b1)  + 2'(cin1);
    assign ref16 = 17'(a16) + 17'(b16) + 17'(cin16);
    assign rov4  = (a4[3]   == b4[3])   && (ref4[3]   != a4[3]);
    assign rov1  = (a1[0]   == b1[0])   && (ref1[0]   != a1[0]);
    assign rov16 = (a16[15] == b16[15]) && (ref16[15] != a16[15]);

    // Expected registered outputs.
    logic        armed = 1'b0;
    logic        mv;
    logic [4:0]  m4;
    logic [1:0]  m1;
    logic [16:0] m16;
    logic        mo4, mo1, mo16;

    always @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
            mv    <= 1'b0;
            m4    <= '0;
            m1    <= '0;
            m16   <= '0;
            mo4   <= 1'b0;
            mo1   <= 1'b0;
            mo16  <= 1'b0;
        end else begin
            mv <= in_valid;
            if (in_valid) begin
                m4   <= ref4;
                m1   <= ref1;
                m16  <= ref16;
                mo4  <= rov4;
                mo1  <= rov1;
                mo16 <= rov16;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all instances.
    always @(negedge clk) begin
        chk("comb_w4",  64'({co4,  s4}),  64'(ref4));
        chk("comb_w1",  64'({co1,  s1}),  64'(ref1));
        chk("comb_w16", 64'({co16, s16}), 64'(ref16));
`ifdef RIPPLE_CARRY_OVF_EN
        chk("ovf_w4",  64'(ov4),  64'(rov4));
        chk("ovf_w1",  64'(ov1),  64'(rov1));
        chk("ovf_w16", 64'(ov16), 64'(rov16));
`endif
        if (armed) begin
            chk("reg_w4",  64'({cor4,  sr4}),  64'(m4));
            chk("reg_w1",  64'({cor1,  sr1}),  64'(m1));
            chk("reg_w16", 64'({cor16, sr16}), 64'(m16));
            chk("vld_w4",  64'(v4),  64'(mv));
            chk("vld_w1",  64'(v1),  64'(mv));
            chk("vld_w16", 64'(v16), 64'(mv));
`ifdef RIPPLE_CARRY_OVF_EN
            chk("ovfr_w4",  64'(ovr4),  64'(mo4));
            chk("ovfr_w1",  64'(ovr1),  64'(mo1));
            chk("ovfr_w16", 64'(ovr16), 64'(mo16));
`endif
        end
    end

    // Drive one cycle of stimulus just after the rising edge; wider instances get random operands.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic v, input logic r);
        @(posedge clk);
        #1;
        a4       = a;
        b4       = b;
        cin4     = c;
        in_valid = v;
        rst      = r;
        a1       = 1'($urandom);
        b1       = 1'($urandom);
        cin1     = 1'($urandom);
        a16      = 16'($urandom);
        b16      = 16'($urandom);
        cin16    = 1'($urandom);
        n_vec++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_r",  64'(sr4),  64'd0);
        chk("rst_cout_r", 64'(cor4), 64'd0);
        chk("rst_vld",    64'(v4),   64'd0);

        // Exhaustive WIDTH=4 with random in_valid exercising the register path.
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    apply(4'(a), 4'(b), 1'(c), 1'($urandom_range(0, 1)), 1'b0);

        // Carry ripple corners pinned to literal results.
        apply(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0); #1;
        chk("wrap", 64'({co4, s4}), 64'b1_0000);
        apply(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0); #1;
        chk("cin_only", 64'({co4, s4}), 64'b0_0001);
        apply(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0); #1;
        chk("max", 64'({co4, s4}), 64'b1_1111);

        // Registered capture, then hold with in_valid low.
        apply(4'b1010, 4'b0111, 1'b0, 1'b1, 1'b0);
        apply(4'b0011, 4'b0100, 1'b1, 1'b0, 1'b0); #1;
        chk("cap_sum_r",  64'(sr4),  64'b0001);
        chk("cap_cout_r", 64'(cor4), 64'd1);
        chk("cap_vld",    64'(v4),   64'd1);
        apply(4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0); #1;
        chk("hold_sum_r", 64'(sr4), 64'b0001);
        chk("hold_vld",   64'(v4),  64'd0);

        // Reset asserted on the third cycle of a valid stream.
        apply(4'b0101, 4'b0110, 1'b0, 1'b1, 1'b0);
        apply(4'b1001, 4'b0011, 1'b1, 1'b1, 1'b0);
        apply(4'b1110, 4'b0111, 1'b0, 1'b1, 1'b1); #1;
        chk("mid_comb", 64'({co4, s4}), 64'b1_0101);
        apply(4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0); #1;
        chk("mid_rst_sum_r", 64'(sr4), 64'd0);
        chk("mid_rst_vld",   64'(v4),  64'd0);

`ifdef RIPPLE_CARRY_OVF_EN
        apply(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0); #1;
        chk("ovf_pos", 64'({ov4, co4, s4}), 64'b1_0_1000);
        apply(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0); #1;
        chk("ovf_neg", 64'({ov4, co4, s4}), 64'b1_1_0111);
        apply(4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0); #1;
        chk("ovf_none", 64'(ov4), 64'd0);
`endif

        // Random sweep: all three widths, random valid and occasional reset.
        for (int i = 0; i < 1000; i++)
            apply(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 31) == 0));

        apply(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
